// File: rtl/ysyx_lsu_pkg.sv
// Shared LSU constants: FSM states and funct3 size/sign codes.
package ysyx_lsu_pkg;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_RADDR,
        LSU_RDATA,
        LSU_WREQ,
        LSU_WRESP,
        LSU_DONE,
        LSU_DROP
    } lsu_state_e;

    localparam logic [2:0] LSU_F3_B  = 3'b000;
    localparam logic [2:0] LSU_F3_H  = 3'b001;
    localparam logic [2:0] LSU_F3_W  = 3'b010;
    localparam logic [2:0] LSU_F3_BU = 3'b100;
    localparam logic [2:0] LSU_F3_HU = 3'b101;

    // Signed and unsigned variants share the low two funct3 bits.
    function automatic logic f3_is_byte(input logic [2:0] f3);
        return f3[1:0] == 2'b00;
    endfunction

    function automatic logic f3_is_half(input logic [2:0] f3);
        return f3[1:0] == 2'b01;
    endfunction

endpackage

// File: rtl/ysyx_lsu_align.sv
// Combinational lane steering: store data/strobe replication and load extract/extend.
module ysyx_lsu_align
    import ysyx_lsu_pkg::*;
#(
    parameter int BIT_W = 32
) (
    input  logic [1:0]         addr_lo,
    input  logic [2:0]         funct3,
    input  logic [BIT_W-1:0]   st_data,
    output logic [BIT_W-1:0]   bus_wdata,
    output logic [BIT_W/8-1:0] bus_wstrb,
    input  logic [BIT_W-1:0]   bus_rdata,
    output logic [BIT_W-1:0]   ld_data
);
    localparam int NB = BIT_W / 8;

    logic [BIT_W-1:0] byte_rep;
    logic [BIT_W-1:0] half_rep;
    logic [NB-1:0]    strb_byte;
    logic [NB-1:0]    strb_half;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_rep
            assign byte_rep[gi*8 +: 8] = st_data[7:0];
            assign half_rep[gi*8 +: 8] = st_data[(gi % 2)*8 +: 8];
        end
    endgenerate

    assign strb_byte = NB'(1);
    assign strb_half = NB'(3);

    always_comb begin
        bus_wdata = st_data;
        bus_wstrb = '1;
        if (f3_is_byte(funct3)) begin
            bus_wdata = byte_rep;
            bus_wstrb = strb_byte << addr_lo;
        end else if (f3_is_half(funct3)) begin
            bus_wdata = half_rep;
            bus_wstrb = strb_half << {addr_lo[1], 1'b0};
        end
    end

    // Halfword lane uses addr[1] only; misaligned low bits are ignored.
    assign lane_b = 8'(bus_rdata >> {addr_lo, 3'b000});
    assign lane_h = 16'(bus_rdata >> {addr_lo[1], 4'b0000});

    always_comb begin
        ld_data = bus_rdata;
        case (funct3)
            LSU_F3_B:  ld_data = {{(BIT_W-8){lane_b[7]}}, lane_b};
            LSU_F3_BU: ld_data = {{(BIT_W-8){1'b0}}, lane_b};
            LSU_F3_H:  ld_data = {{(BIT_W-16){lane_h[15]}}, lane_h};
            LSU_F3_HU: ld_data = {{(BIT_W-16){1'b0}}, lane_h};
            default:   ld_data = bus_rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_lsu.sv
// EXU-facing load/store unit: one AXI4-Lite transaction per request, registered outputs.
module ysyx_lsu
    import ysyx_lsu_pkg::*;
#(
    parameter int BIT_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lsu_avalid,
    input  logic               lsu_ren,
    input  logic               lsu_wen,
    input  logic [ADDR_W-1:0]  lsu_addr,
    input  logic [BIT_W-1:0]   lsu_wdata,
    input  logic [2:0]         lsu_funct3,
    output logic [BIT_W-1:0]   lsu_rdata_o,
    output logic               lsu_exu_rvalid,
    output logic               lsu_exu_wready,
    output logic               lsu_fault_o,
    output logic [ADDR_W-1:0]  araddr,
    output logic               arvalid,
    input  logic               arready,
    input  logic [BIT_W-1:0]   rdata,
    input  logic [1:0]         rresp,
    input  logic               rvalid,
    output logic               rready,
    output logic [ADDR_W-1:0]  awaddr,
    output logic               awvalid,
    input  logic               awready,
    output logic [BIT_W-1:0]   wdata,
    output logic [BIT_W/8-1:0] wstrb,
    output logic               wvalid,
    input  logic               wready,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready
);
    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BIT_W-1:0]  wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              exu_rvalid_q, exu_rvalid_d;
    logic              exu_wready_q, exu_wready_d;
    logic              fault_q, fault_d;
    logic [BIT_W-1:0]  rdata_o_q, rdata_o_d;
    logic [BIT_W-1:0]  ld_data;

    ysyx_lsu_align #(.BIT_W(BIT_W)) u_align (
        .addr_lo   (addr_q[1:0]),
        .funct3    (funct3_q),
        .st_data   (wdata_q),
        .bus_wdata (wdata),
        .bus_wstrb (wstrb),
        .bus_rdata (rdata),
        .ld_data   (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        exu_rvalid_d = 1'b0;
        exu_wready_d = 1'b0;
        fault_d      = fault_q;
        rdata_o_d    = rdata_o_q;
        case (state_q)
            LSU_IDLE: begin
                if (lsu_avalid && (lsu_wen || lsu_ren)) begin
                    addr_d   = lsu_addr;
                    wdata_d  = lsu_wdata;
                    funct3_d = lsu_funct3;
                    if (lsu_wen) begin
                        state_d   = LSU_WREQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = LSU_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            LSU_RADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = LSU_RDATA;
                end
            end
            LSU_RDATA: begin
                if (rvalid) begin
                    rready_d     = 1'b0;
                    rdata_o_d    = ld_data;
                    fault_d      = (rresp != 2'b00);
                    exu_rvalid_d = 1'b1;
                    state_d      = LSU_DONE;
                end
            end
            LSU_WREQ: begin
                // AW and W retire independently; a channel already retired counts as done.
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
                    bready_d = 1'b1;
                    state_d  = LSU_WRESP;
                end
            end
            LSU_WRESP: begin
                if (bvalid) begin
                    bready_d     = 1'b0;
                    fault_d      = (bresp != 2'b00);
                    exu_wready_d = 1'b1;
                    state_d      = LSU_DONE;
                end
            end
            LSU_DONE: state_d = LSU_DROP;
            LSU_DROP: begin
                // EXU drops avalid a cycle late; wait it out so the request is not re-issued.
                if (!lsu_avalid) state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= LSU_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            exu_rvalid_q <= 1'b0;
            exu_wready_q <= 1'b0;
            fault_q      <= 1'b0;
            rdata_o_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            exu_rvalid_q <= exu_rvalid_d;
            exu_wready_q <= exu_wready_d;
            fault_q      <= fault_d;
            rdata_o_q    <= rdata_o_d;
        end
    end

    assign araddr         = {addr_q[ADDR_W-1:2], 2'b00};
    assign awaddr         = {addr_q[ADDR_W-1:2], 2'b00};
    assign arvalid        = arvalid_q;
    assign rready         = rready_q;
    assign awvalid        = awvalid_q;
    assign wvalid         = wvalid_q;
    assign bready         = bready_q;
    assign lsu_exu_rvalid = exu_rvalid_q;
    assign lsu_exu_wready = exu_wready_q;
    assign lsu_fault_o    = fault_q;
    assign lsu_rdata_o    = rdata_o_q;

endmodule

// File: tb/tb_ysyx_lsu.sv
// Scoreboard bench for ysyx_lsu with a configurable-latency AXI4-Lite slave model.
module tb_ysyx_lsu;
    import ysyx_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_avalid, lsu_ren, lsu_wen;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_rdata_o;
    logic        lsu_exu_rvalid, lsu_exu_wready, lsu_fault_o;
    logic [31:0] araddr, awaddr, wdata;
    logic        arvalid, arready, rready, awvalid, awready, wvalid, wready, bready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0, bresp = '0;
    logic        rvalid = 1'b0, bvalid = 1'b0;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    ysyx_lsu #(.BIT_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .lsu_avalid(lsu_avalid), .lsu_ren(lsu_ren), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_funct3(lsu_funct3),
        .lsu_rdata_o(lsu_rdata_o), .lsu_exu_rvalid(lsu_exu_rvalid),
        .lsu_exu_wready(lsu_exu_wready), .lsu_fault_o(lsu_fault_o),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0;
    logic        r_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] mem_word = '0;
    logic [1:0]  rresp_cfg = '0, bresp_cfg = '0;
    logic [31:0] exp_baddr = '0, exp_wdata = '0;
    logic [3:0]  exp_wstrb = '0;

    assign arready = arvalid && (ar_cnt >= ar_dly);
    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid  && (w_cnt  >= w_dly);

    // Handshakes sampled mid-cycle; the slave state advances on the following edge.
    logic        ar_hs_n = 0, aw_hs_n = 0, w_hs_n = 0, r_hs_n = 0, b_hs_n = 0;
    logic        arv_n = 0, awv_n = 0, wv_n = 0;
    logic        aw_stall_n = 0, w_stall_n = 0;
    logic [31:0] aw_prev = '0, w_prev = '0;
    logic [3:0]  ws_prev = '0;
    int          ar_hs_cnt = 0, aw_hs_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (aw_stall_n) begin
                check("aw_hold", 32'(awvalid), 32'd1);
                check("aw_stable", awaddr, aw_prev);
            end
            if (w_stall_n) begin
                check("w_hold", 32'(wvalid), 32'd1);
                check("wdata_stable", wdata, w_prev);
                check("wstrb_stable", 32'(wstrb), 32'(ws_prev));
            end
        end
        ar_hs_n = arvalid && arready;
        aw_hs_n = awvalid && awready;
        w_hs_n  = wvalid && wready;
        r_hs_n  = rvalid && rready;
        b_hs_n  = bvalid && bready;
        arv_n   = arvalid;
        awv_n   = awvalid;
        wv_n    = wvalid;
        if (rst && ar_hs_n) begin
            ar_hs_cnt++;
            check("araddr", araddr, exp_baddr);
        end
        if (rst && aw_hs_n) begin
            aw_hs_cnt++;
            check("awaddr", awaddr, exp_baddr);
        end
        if (rst && w_hs_n) begin
            check("wdata", wdata, exp_wdata);
            check("wstrb", 32'(wstrb), 32'(exp_wstrb));
        end
        aw_stall_n = rst && awvalid && !awready;
        w_stall_n  = rst && wvalid && !wready;
        aw_prev    = awaddr;
        w_prev     = wdata;
        ws_prev    = wstrb;
    end

    always @(posedge clk) begin
        if (!rst) begin
            rvalid <= 1'b0; bvalid <= 1'b0; rdata <= '0; rresp <= '0; bresp <= '0;
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
            r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            ar_cnt <= (arv_n && !ar_hs_n) ? ar_cnt + 1 : 0;
            aw_cnt <= (awv_n && !aw_hs_n) ? aw_cnt + 1 : 0;
            w_cnt  <= (wv_n && !w_hs_n) ? w_cnt + 1 : 0;
            if (ar_hs_n) begin
                rdata <= mem_word;
                rresp <= rresp_cfg;
                if (r_dly == 0) rvalid <= 1'b1;
                else begin
                    r_pend <= 1'b1;
                    r_cnt  <= r_dly - 1;
                end
            end else if (r_pend) begin
                if (r_cnt == 0) begin
                    rvalid <= 1'b1;
                    r_pend <= 1'b0;
                end else r_cnt <= r_cnt - 1;
            end
            if (r_hs_n) rvalid <= 1'b0;
            if ((aw_got || aw_hs_n) && (w_got || w_hs_n)) begin
                bvalid <= 1'b1;
                bresp  <= bresp_cfg;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                aw_got <= aw_got || aw_hs_n;
                w_got  <= w_got || w_hs_n;
            end
            if (b_hs_n) bvalid <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        is_load;
        logic [31:0] rd;
        logic        fault;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  pulse_cnt = 0;
    int  pulse_cyc = 0;

    always @(negedge clk) begin
        if (rst && (lsu_exu_rvalid || lsu_exu_wready)) begin
            pulse_cnt++;
            pulse_cyc = cyc;
            if (sb_q.size() == 0) begin
                check("extra_pulse", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_kind", 32'({lsu_exu_rvalid, lsu_exu_wready}),
                      mon_e.is_load ? 32'd2 : 32'd1);
                if (mon_e.is_load) check("rdata_o", lsu_rdata_o, mon_e.rd);
                check("fault", 32'(lsu_fault_o), 32'(mon_e.fault));
            end
            $display("txn %0d cyc %0d: %s rdata_o=0x%08h fault=%0b", pulse_cnt, cyc,
                     lsu_exu_rvalid ? "load " : "store", lsu_rdata_o, lsu_fault_o);
        end
    end

    task automatic check_outs_zero();
        check("rst_rvalid", 32'(lsu_exu_rvalid), 32'd0);
        check("rst_wready", 32'(lsu_exu_wready), 32'd0);
        check("rst_fault", 32'(lsu_fault_o), 32'd0);
        check("rst_rdata_o", lsu_rdata_o, 32'd0);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid", 32'(wvalid), 32'd0);
        check("rst_bready", 32'(bready), 32'd0);
    endtask

    task automatic do_req(input logic r, input logic w, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input logic [31:0] exp_rd, input logic [31:0] exp_wd,
                          input logic [3:0] exp_ws, input logic exp_fault,
                          input int exp_lat, input int hold);
        int  start, pc, ab, wb, waited;
        sb_t e;
        exp_baddr = addr & 32'hFFFF_FFFC;
        exp_wdata = exp_wd;
        exp_wstrb = exp_ws;
        e.is_load = r && !w;
        e.rd      = exp_rd;
        e.fault   = exp_fault;
        sb_q.push_back(e);
        ab = ar_hs_cnt;
        wb = aw_hs_cnt;
        @(negedge clk);
        lsu_avalid = 1'b1; lsu_ren = r; lsu_wen = w;
        lsu_addr = addr; lsu_wdata = wd; lsu_funct3 = f3;
        start  = cyc;
        pc     = pulse_cnt;
        waited = 0;
        while (pulse_cnt == pc && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (pulse_cnt == pc) begin
            check("timeout", 32'd0, 32'd1);
            sb_q.delete();
        end else if (exp_lat != 0) begin
            check("latency", 32'(pulse_cyc - start), 32'(exp_lat));
        end
        repeat (hold) @(negedge clk);
        lsu_avalid = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0;
        repeat (2) @(negedge clk);
        check("bus_txn", 32'((ar_hs_cnt - ab) + (aw_hs_cnt - wb)), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ab, wb, pc;
        rst = 1'b0;
        lsu_avalid = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0;
        lsu_addr = '0; lsu_wdata = '0; lsu_funct3 = '0;
        repeat (3) @(negedge clk);
        check_outs_zero();
        rst = 1'b1;
        @(negedge clk);

        // Loads with lane select and extension
        mem_word = 32'hDEADBEEF;
        do_req(1, 0, 32'h8000_0004, 0, LSU_F3_W,  32'hDEADBEEF, 0, 0, 0, 3, 0);
        mem_word = 32'h80FF1234;
        do_req(1, 0, 32'h8000_0003, 0, LSU_F3_B,  32'hFFFFFF80, 0, 0, 0, 3, 0);
        do_req(1, 0, 32'h8000_0003, 0, LSU_F3_BU, 32'h00000080, 0, 0, 0, 3, 0);
        do_req(1, 0, 32'h8000_0002, 0, LSU_F3_HU, 32'h000080FF, 0, 0, 0, 3, 0);
        do_req(1, 0, 32'h8000_0002, 0, LSU_F3_H,  32'hFFFF80FF, 0, 0, 0, 3, 0);
        do_req(1, 0, 32'h8000_0000, 0, LSU_F3_B,  32'h00000034, 0, 0, 0, 3, 0);

        // Stores with strobe/data steering
        do_req(0, 1, 32'h8000_0008, 32'h12345678, LSU_F3_W, 0, 32'h12345678, 4'b1111, 0, 3, 0);
        do_req(0, 1, 32'h8000_0001, 32'h000000AB, LSU_F3_B, 0, 32'hABABABAB, 4'b0010, 0, 3, 0);
        do_req(0, 1, 32'h8000_0002, 32'h0000BEEF, LSU_F3_H, 0, 32'hBEEFBEEF, 4'b1100, 0, 3, 0);

        // AW accepted three cycles after W
        aw_dly = 3;
        do_req(0, 1, 32'h8000_0003, 32'h0000005A, LSU_F3_B, 0, 32'h5A5A5A5A, 4'b1000, 0, 6, 0);
        aw_dly = 0;

        // avalid held past the completion pulse
        mem_word = 32'hCAFEF00D;
        do_req(1, 0, 32'h8000_000C, 0, LSU_F3_W, 32'hCAFEF00D, 0, 0, 0, 3, 2);

        // ren and wen both set: treated as a store
        do_req(1, 1, 32'h8000_0010, 32'h01020304, LSU_F3_W, 0, 32'h01020304, 4'b1111, 0, 3, 0);

        // avalid with neither ren nor wen is ignored
        ab = ar_hs_cnt; wb = aw_hs_cnt; pc = pulse_cnt;
        @(negedge clk);
        lsu_avalid = 1'b1; lsu_ren = 1'b0; lsu_wen = 1'b0;
        repeat (4) @(negedge clk);
        lsu_avalid = 1'b0;
        repeat (2) @(negedge clk);
        check("ignored_bus", 32'((ar_hs_cnt - ab) + (aw_hs_cnt - wb)), 32'd0);
        check("ignored_pulse", 32'(pulse_cnt - pc), 32'd0);

        // Bus errors and recovery
        rresp_cfg = 2'b10; mem_word = 32'h11110000;
        do_req(1, 0, 32'h8000_0014, 0, LSU_F3_W, 32'h11110000, 0, 0, 1, 3, 0);
        rresp_cfg = 2'b00; mem_word = 32'h22223333;
        do_req(1, 0, 32'h8000_0018, 0, LSU_F3_W, 32'h22223333, 0, 0, 0, 3, 0);
        bresp_cfg = 2'b10;
        do_req(0, 1, 32'h8000_001C, 32'h99998888, LSU_F3_W, 0, 32'h99998888, 4'b1111, 1, 3, 0);
        bresp_cfg = 2'b00;

        // Reset while waiting in RDATA
        r_dly = 5; mem_word = 32'h44445555;
        @(negedge clk);
        lsu_avalid = 1'b1; lsu_ren = 1'b1; lsu_wen = 1'b0;
        lsu_addr = 32'h8000_0020; lsu_funct3 = LSU_F3_W;
        exp_baddr = 32'h8000_0020;
        repeat (3) @(negedge clk);
        #1;
        check("in_rdata", 32'(rready), 32'd1);
        rst = 1'b0;
        lsu_avalid = 1'b0; lsu_ren = 1'b0;
        @(negedge clk);
        #1;
        check_outs_zero();
        rst = 1'b1;
        r_dly = 0;
        @(negedge clk);

        mem_word = 32'h5555AAAA;
        do_req(1, 0, 32'h8000_0024, 0, LSU_F3_W, 32'h5555AAAA, 0, 0, 0, 3, 0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
